// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer with a 2-entry output queue.
// Define SIPO_PARITY_CHECK_EN to expect and check an even-parity bit per word.
module sipo_deframer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ser_in,
   input  logic             ser_en,
   input  logic             frame_start,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_perr,
   output logic [1:0]       level,
   output logic             frame_err,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_ferr;
   logic [WIDTH-1:0] r_q0, r_q1;
   logic             r_p0, r_p1;
   logic [1:0]       r_level;
   logic             r_ovf;

   logic             w_start;
   logic             w_last;
   logic [WIDTH-1:0] w_word;
   logic             w_push;
   logic [WIDTH-1:0] w_pdata;
   logic             w_pperr;
   logic             w_pop;

   assign w_start = ser_en && frame_start;
   assign w_word  = {r_shift[WIDTH-2:0], ser_in};
   assign w_last  = (r_state == S_SHIFT) && ser_en && !frame_start &&
                    (r_cnt == CW'(WIDTH - 1));

`ifdef SIPO_PARITY_CHECK_EN
   assign w_push  = (r_state == S_PARITY) && ser_en && !frame_start;
   assign w_pdata = r_shift;
   assign w_pperr = ^{r_shift, ser_in};
`else
   assign w_push  = w_last;
   assign w_pdata = w_word;
   assign w_pperr = 1'b0;
`endif

   assign w_pop = (r_level != 2'd0) && out_ready;

   // A start strobe always wins, even over the final bit of a word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_ferr  <= 1'b0;
      end else begin
         r_ferr <= w_start && (r_state != S_IDLE);
         if (w_start) begin
            r_shift <= {{(WIDTH-1){1'b0}}, ser_in};
            r_cnt   <= CW'(1);
            r_state <= S_SHIFT;
         end else if (ser_en) begin
            case (r_state)
               S_SHIFT: begin
                  r_shift <= w_word;
                  r_cnt   <= r_cnt + CW'(1);
                  if (w_last) begin
                     r_cnt <= '0;
`ifdef SIPO_PARITY_CHECK_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_IDLE;
`endif
                  end
               end
`ifdef SIPO_PARITY_CHECK_EN
               S_PARITY: r_state <= S_IDLE;
`endif
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Head entry is kept at zero whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q0    <= '0;
         r_q1    <= '0;
         r_p0    <= 1'b0;
         r_p1    <= 1'b0;
         r_level <= 2'd0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_level)
            2'd0: begin
               if (w_push) begin
                  r_q0    <= w_pdata;
                  r_p0    <= w_pperr;
                  r_level <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_q0 <= w_pdata;
                  r_p0 <= w_pperr;
               end else if (w_push) begin
                  r_q1    <= w_pdata;
                  r_p1    <= w_pperr;
                  r_level <= 2'd2;
               end else if (w_pop) begin
                  r_q0    <= '0;
                  r_p0    <= 1'b0;
                  r_level <= 2'd0;
               end
            end
            2'd2: begin
               if (w_pop) begin
                  r_q0 <= r_q1;
                  r_p0 <= r_p1;
                  if (w_push) begin
                     r_q1 <= w_pdata;
                     r_p1 <= w_pperr;
                  end else begin
                     r_q1    <= '0;
                     r_p1    <= 1'b0;
                     r_level <= 2'd1;
                  end
               end else if (w_push) begin
                  r_ovf <= 1'b1;
               end
            end
            default: r_level <= 2'd0;
         endcase
      end
   end

   assign out_data  = r_q0;
   assign out_perr  = r_p0;
   assign out_valid = (r_level != 2'd0);
   assign level     = r_level;
   assign frame_err = r_ferr;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer (WIDTH=4); parity cases only
// run when SIPO_PARITY_CHECK_EN is defined.
module tb_sipo_deframer;

   logic       clk = 1'b0;
   logic       reset;
   logic       ser_in;
   logic       ser_en;
   logic       frame_start;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_perr;
   logic [1:0] level;
   logic       frame_err;
   logic       overflow;

   int n_chk = 0;
   int n_err = 0;

   sipo_deframer #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .ser_in      (ser_in),
      .ser_en      (ser_en),
      .frame_start (frame_start),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_perr    (out_perr),
      .level       (level),
      .frame_err   (frame_err),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic fs);
      ser_in      = b;
      ser_en      = 1'b1;
      frame_start = fs;
      tick();
      ser_en      = 1'b0;
      frame_start = 1'b0;
      ser_in      = 1'b0;
   endtask

   task automatic send_par(input logic [3:0] w);
`ifdef SIPO_PARITY_CHECK_EN
      send_bit(^w, 1'b0);
`else
      if (w == 4'h0) ser_in = 1'b0;
`endif
   endtask

   task automatic send_word(input logic [3:0] w);
      send_bit(w[3], 1'b1);
      send_bit(w[2], 1'b0);
      send_bit(w[1], 1'b0);
      send_bit(w[0], 1'b0);
      send_par(w);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset       = 1'b1;
      ser_in      = 1'b0;
      ser_en      = 1'b0;
      frame_start = 1'b0;
      out_ready   = 1'b1;
      idle(2);
      chk("rst_data", out_data, 4'h0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_perr", out_perr, 1'b0);
      chk("rst_level", level, 2'd0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      reset = 1'b0;
      idle(1);

      // 1: basic word
      send_word(4'hB);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_data", out_data, 4'hB);
      chk("t1_perr", out_perr, 1'b0);
      chk("t1_level", level, 2'd1);
      tick();
      chk("t1_pop_level", level, 2'd0);
      chk("t1_pop_valid", out_valid, 1'b0);

      // 2: gapped bits
      send_bit(1'b1, 1'b1); idle(3);
      send_bit(1'b0, 1'b0); idle(3);
      send_bit(1'b1, 1'b0); idle(3);
      chk("t2_gap_valid", out_valid, 1'b0);
      send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
      idle(3);
      chk("t2_par_gap", out_valid, 1'b0);
      send_par(4'hB);
`endif
      chk("t2_data", out_data, 4'hB);
      chk("t2_valid", out_valid, 1'b1);
      tick();

      // 3: backpressure and overflow
      out_ready = 1'b0;
      send_word(4'hA);
      chk("t3_lvl1", level, 2'd1);
      send_word(4'h5);
      chk("t3_lvl2", level, 2'd2);
      chk("t3_ovf0", overflow, 1'b0);
      send_word(4'hC);
      chk("t3_lvl_full", level, 2'd2);
      chk("t3_ovf1", overflow, 1'b1);
      chk("t3_head", out_data, 4'hA);
      out_ready = 1'b1;
      tick();
      chk("t3_pop1", out_data, 4'h5);
      chk("t3_pop1_lvl", level, 2'd1);
      tick();
      chk("t3_empty", out_valid, 1'b0);
      chk("t3_empty_lvl", level, 2'd0);
      chk("t3_empty_data", out_data, 4'h0);
      chk("t3_ovf_sticky", overflow, 1'b1);

      // 4: mid-word restart
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      chk("t4_ferr_pre", frame_err, 1'b0);
      send_bit(1'b0, 1'b1);
      chk("t4_ferr", frame_err, 1'b1);
      send_bit(1'b1, 1'b0);
      chk("t4_ferr_clr", frame_err, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("t4_nopush", out_valid, 1'b0);
      send_bit(1'b0, 1'b0);
      send_par(4'h6);
      chk("t4_data", out_data, 4'h6);
      chk("t4_valid", out_valid, 1'b1);
      tick();
      chk("t4_drain", level, 2'd0);

      // 5: reset with full queue and partial word
      out_ready = 1'b0;
      send_word(4'hA);
      send_word(4'h5);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      chk("t5_full", level, 2'd2);
      reset = 1'b1;
      tick();
      chk("t5_data", out_data, 4'h0);
      chk("t5_valid", out_valid, 1'b0);
      chk("t5_level", level, 2'd0);
      chk("t5_ovf", overflow, 1'b0);
      chk("t5_ferr", frame_err, 1'b0);
      reset = 1'b0;
      out_ready = 1'b1;
      // tail bits of the old word must be ignored in IDLE
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("t5_idle", out_valid, 1'b0);
      send_word(4'h3);
      chk("t5_new", out_data, 4'h3);
      chk("t5_new_valid", out_valid, 1'b1);
      tick();

`ifdef SIPO_PARITY_CHECK_EN
      // 6: parity good and bad
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("t6_wait_par", out_valid, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("t6_good_data", out_data, 4'hB);
      chk("t6_good_perr", out_perr, 1'b0);
      tick();
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      chk("t6_bad_data", out_data, 4'hB);
      chk("t6_bad_perr", out_perr, 1'b1);
      tick();
`else
      // 6: no parity stage; odd-parity word still reports no error
      send_word(4'h7);
      chk("t6_data", out_data, 4'h7);
      chk("t6_perr", out_perr, 1'b0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Downstream companion to the team's 4-bit PISO register. Receives its MSB-first serial stream and rebuilds parallel words.
- Frame alignment comes from a start-of-word strobe.
- Completed words are buffered in a 2-entry output queue with a valid/ready handshake toward the consuming logic.
- Reports framing errors and queue overflow.

Parameters:
- WIDTH, 4, data bits per word, MSB first; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; one clock domain.
- ser_in  input  1  serial data bit.
- ser_en  input  1  ser_in is valid this cycle; no bit is consumed when low.
- frame_start  input  1  qualified by ser_en; marks the current bit as the MSB of a new word.
- out_data  output  WIDTH  head-of-queue word.
- out_valid  output  1  queue non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- out_perr  output  1  parity error flag of the head word (see Optional Feature).
- level  output  2  queue occupancy, 0..2.
- frame_err  output  1  one-cycle pulse on a mid-word restart.
- overflow  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs):
  - out_data=0, out_valid=0, out_perr=0, level=0, frame_err=0, overflow=0.
  - Shift register and bit counter cleared; FSM returns to IDLE.
  - A partial word is discarded and the queue is emptied.
- FSM state IDLE:
  - ser_en && frame_start: capture ser_in as MSB, bit_cnt=1, go to SHIFT.
  - ser_en without frame_start: bit ignored.
- FSM state SHIFT:
  - Each ser_en cycle: shift_reg <= {shift_reg[WIDTH-2:0], ser_in}, bit_cnt++.
  - ser_en low: all state holds.
  - On the edge that captures bit WIDTH, the assembled word is pushed into the queue and the FSM returns to IDLE, or to PARITY when the optional feature is enabled.
- Mid-word restart: ser_en && frame_start while in SHIFT (or PARITY):
  - The partial word is discarded.
  - The current bit becomes the new MSB, bit_cnt=1, and the FSM stays in or enters SHIFT.
  - frame_err pulses high for exactly the following cycle.
- Word completion with the same-cycle frame_start: frame_start wins. The restart rule applies and no word is pushed.
- Latency: out_valid rises on the cycle after the clock edge that captured the final bit, when the queue was empty.
- Queue (2 entries, FIFO order):
  - out_data/out_perr always reflect the head entry; they are 0 when empty.
  - Pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle are both performed at any level. When full, the pop frees a slot, the push is accepted, and level stays 2.
  - Push when level=2 with no pop: the word is dropped, overflow is set to 1 and remains set until reset. Queue contents are unchanged.
  - level is updated on the same edge as the push/pop.
- Back-to-back words with no idle cycles are supported, with a sustained rate of 1 bit per cycle.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - After bit WIDTH, the FSM enters PARITY and waits for one more ser_en bit, an even-parity bit.
  - The word is pushed on the edge that captures the parity bit.
  - The stored out_perr is the XOR of all data bits and the parity bit; 1 means error.
  - frame_start during PARITY follows the restart rule and the word is discarded.
- Not defined:
  - No PARITY state exists; the word is pushed on bit WIDTH.
  - out_perr is tied to 0. The port exists in both builds.

Test Plan:
1. Basic word: reset 2 cycles, then frame_start=1 with bits 1,0,1,1 on consecutive ser_en cycles, out_ready=1 -> out_data=4'b1011 and out_valid=1 on the cycle after the 4th bit. The word pops that cycle and level returns to 0.
2. Gapped input: the same bits with ser_en low for 3 cycles between each bit -> identical out_data=4'hB. No state change during gaps.
3. Backpressure/overflow: out_ready=0, send words 4'hA, 4'h5, 4'hC -> level=2, overflow=1, 4'hC dropped. Then out_ready=1 -> 4'hA, then 4'h5, then out_valid=0, level=0; overflow stays 1.
4. Mid-word restart: frame_start with bits 1,1, then frame_start again with bits 0,1,1,0 -> frame_err pulses one cycle after the second frame_start. The only output word is 4'h6.
5. Reset mid-word and with a full queue: after 2 of 4 bits, with level=2, assert reset -> all outputs 0, level=0. The next full word 4'h3 is delivered normally.
6. With SIPO_PARITY_CHECK_EN defined: data 1011 + parity 1 -> out_perr=0. Data 1011 + parity 0 -> out_perr=1. Without the macro, out_perr=0 throughout.
